// File: rtl/stream_demux_router.sv
// 1-to-N_OUT packet demux: destination latched on first beat, held to last; bad destinations dropped and counted.
// Latency: one cycle through a single registered output entry, full throughput with pass-through on load+drain.
// Backpressure: up_ready follows the selected output's ready only; stalls hold the entry stable; drops always accept.
module stream_demux_router #(
    parameter int N_OUT = 4,
    parameter int W = 8,
    localparam int SEL_W = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic             up_last,
    input  logic [SEL_W-1:0] up_sel,
    output logic [N_OUT-1:0] down_valid,
    input  logic [N_OUT-1:0] down_ready,
    output logic [W-1:0]     down_data,
    output logic             down_last,
    output logic [SEL_W-1:0] cur_dest,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    typedef struct packed {
        logic [W-1:0]     dat;
        logic             last;
        logic [SEL_W-1:0] dest;
    } buf_t;

    // One extra bit so N_OUT itself is representable when N_OUT is a power of 2.
    localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

    state_t           state, state_nxt;
    logic             buf_vld;
    buf_t             buf_q;
    logic [N_OUT-1:0] dest_hot;
    logic             drain;
    logic             accept;
    logic             load;
    logic             drop_first;
    logic             sel_ok;
    logic [SEL_W-1:0] load_dest;

    assign dest_hot   = N_OUT'(1) << buf_q.dest;
    assign down_valid = buf_vld ? dest_hot : '0;
    assign down_data  = buf_q.dat;
    assign down_last  = buf_q.last;
    assign drain      = |(down_valid & down_ready);
    assign sel_ok     = ({1'b0, up_sel} < N_OUT_L);
    assign load_dest  = (state == IDLE) ? up_sel : cur_dest;

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        drop_first = 1'b0;
        up_ready   = (state == DROP) ? 1'b1 : (!buf_vld || drain);
        accept     = up_valid && up_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        load      = 1'b1;
                        state_nxt = up_last ? IDLE : ROUTE;
                    end else begin
                        drop_first = 1'b1;
                        state_nxt  = up_last ? IDLE : DROP;
                    end
                end
            end
            ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (up_last) state_nxt = IDLE;
                end
            end
            DROP: begin
                if (accept && up_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            buf_vld  <= 1'b0;
            buf_q    <= '0;
            cur_dest <= '0;
        end else begin
            state <= state_nxt;
            // A load in the same cycle as a drain overwrites the entry and keeps it valid.
            if (load) begin
                buf_vld <= 1'b1;
                buf_q   <= '{dat: up_data, last: up_last, dest: load_dest};
            end else if (drain) begin
                buf_vld <= 1'b0;
            end
            if (load && (state == IDLE)) cur_dest <= up_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_first && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: doc/stream_demux_router.md
Name: stream_demux_router

Overview:
- 1-to-N_OUT packet demultiplexer on a valid/ready stream; the sequential counterpart of the mux primitive used in the combinational-logic blocks.
- The destination is sampled on the first beat of each packet and locked until the last beat.
- A single registered output stage gives 1-cycle latency at full throughput.
- Packets addressed to a non-existent output are consumed, discarded and counted.

Parameters:
N_OUT, 4, number of downstream outputs (2..16, need not be a power of 2)
W, 8, data width in bits
SEL_W is a derived localparam, not overridable: $clog2(N_OUT), minimum 1.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
up_valid  in  1  upstream beat valid
up_ready  out  1  upstream beat accepted when up_valid && up_ready
up_data  in  W  upstream data
up_last  in  1  last beat of packet
up_sel  in  SEL_W  destination; sampled only on the first beat of a packet
down_valid  out  N_OUT  one-hot valid, bit i = output i
down_ready  in  N_OUT  per-output ready
down_data  out  W  shared data to all outputs
down_last  out  1  shared last flag
cur_dest  out  SEL_W  currently locked destination (debug)
drop_cnt  out  8  count of dropped packets, saturating

Behaviour:
- Reset (async, any time, including mid-packet): state=IDLE; buf_valid=0; down_valid=0; down_data=0; down_last=0; cur_dest=0; drop_cnt=0. A partially routed packet is abandoned; no beat is emitted after reset.
- Output stage: one entry holding buf_valid, buf_data, buf_last, buf_dest.
  - down_valid = buf_valid ? (1 << buf_dest) : 0
  - down_data = buf_data; down_last = buf_last
  - The entry drains when down_ready[buf_dest] is high; other down_ready bits are ignored.
- Ready:
  - IDLE/ROUTE: up_ready = !buf_valid || down_ready[buf_dest]
  - DROP: up_ready = 1
  - up_ready never depends on up_valid, up_sel or up_data.
- FSM, evaluated on an accepted beat (up_valid && up_ready):
  - IDLE, up_sel < N_OUT:
    - load buffer with data/last; buf_dest = cur_dest = up_sel
    - next state = up_last ? IDLE : ROUTE
  - IDLE, up_sel >= N_OUT:
    - beat discarded; buffer untouched (it may still drain this cycle)
    - drop_cnt += 1, saturating at 255
    - next state = up_last ? IDLE : DROP
  - ROUTE:
    - up_sel ignored; load buffer with buf_dest = cur_dest
    - up_last -> IDLE
  - DROP:
    - discard beat; drop_cnt unchanged
    - up_last -> IDLE
  - No accepted beat: state and cur_dest hold.
- Load and drain in the same cycle: the buffer is overwritten, buf_valid stays 1 (pass-through, 1 beat/cycle).
- Drain with no load: buf_valid -> 0.
- Latency: beat accepted at edge k is visible on down_* after edge k and stays until consumed.
- Ordering: beats leave in acceptance order. Consecutive packets to different outputs are allowed back-to-back; the new packet's first beat can load in the same cycle the old last beat drains.
- cur_dest holds its value in IDLE after a packet completes, and is unchanged by dropped packets.
- down_valid is stable while unconsumed: a valid beat is never retracted and its data never changes until its down_ready is seen.

Test Plan:
- N_OUT=4: four single-beat packets, sel=0,1,2,3, data 0xA0..0xA3, all down_ready=1. down_valid = 0001,0010,0100,1000 on consecutive cycles, each one cycle after its accept; data matches; up_ready stays 1.
- 3-beat packet with sel=2 on beat 1, then up_sel driven to 0 and 1 on beats 2-3. All three beats appear on output 2 with down_last only on beat 3; cur_dest=2 throughout.
- Packet to output 1 with down_ready[1]=0 for 5 cycles while down_ready[0,2,3]=1:
  - up_ready=0 after the first beat loads
  - down_data holds and down_valid=0010 stays stable
  - after down_ready[1]=1, one beat per cycle resumes with no loss or duplication
- N_OUT=3, sel=3 four-beat packet followed by a sel=0 single beat. The 4 beats are accepted with up_ready=1 and none appears downstream; drop_cnt=1; the next beat routes to output 0.
- N_OUT=3: 300 single-beat packets with sel=3. drop_cnt saturates at 255.
- Assert rst asynchronously (between edges) after beat 2 of a 4-beat packet to output 3. down_valid=0 immediately; state=IDLE; cur_dest=0. After release, the next packet's first beat is routed by its own up_sel.
